// File: rtl/dot_product_engine_if.sv
// ---------------------------------------------------------------------------
// dot_product_engine_if
//   Bundles the control and SRAM-side signals of the dot product engine.
//   slave  : the engine. It receives start, len_words, out_addr and the read
//            data of both input SRAMs. It drives status, the input-SRAM read
//            strobes and the output-SRAM write port.
//   master : the parent or environment. It is the mirror of slave.
// Signals
//   start, len_words, out_addr          request from the parent
//   busy, done, result, overflow        status back to the parent
//   in_cs, in_en_read, in_read_addr     read port shared by in0/in1 SRAMs
//   in0_read_data, in1_read_data        read data, 1 cycle after the address
//   out_cs, out_en_write, out_write_addr, out_write_data   output SRAM write
// ---------------------------------------------------------------------------
interface dot_product_engine_if #(
  parameter int Data_Width_In  = 8,
  parameter int Data_Width_Out = 16,
  parameter int Addr_Width     = 4,
  parameter int Para_Deg       = 2
);
  logic                               start;
  logic [Addr_Width:0]                len_words;
  logic [Addr_Width-1:0]              out_addr;
  logic                               busy;
  logic                               done;
  logic [Data_Width_Out-1:0]          result;
  logic                               overflow;
  logic                               in_cs;
  logic                               in_en_read;
  logic [Addr_Width-1:0]              in_read_addr;
  logic [Para_Deg*Data_Width_In-1:0]  in0_read_data;
  logic [Para_Deg*Data_Width_In-1:0]  in1_read_data;
  logic                               out_cs;
  logic                               out_en_write;
  logic [Addr_Width-1:0]              out_write_addr;
  logic [Para_Deg*Data_Width_Out-1:0] out_write_data;

  modport slave (
    input  start, len_words, out_addr, in0_read_data, in1_read_data,
    output busy, done, result, overflow,
    output in_cs, in_en_read, in_read_addr,
    output out_cs, out_en_write, out_write_addr, out_write_data
  );

  modport master (
    output start, len_words, out_addr, in0_read_data, in1_read_data,
    input  busy, done, result, overflow,
    input  in_cs, in_en_read, in_read_addr,
    input  out_cs, out_en_write, out_write_addr, out_write_data
  );
endinterface

// File: rtl/dot_product_engine.sv
// ---------------------------------------------------------------------------
// dot_product_engine
//   A start pulse triggers a run. The engine streams L = min(len_words,
//   Ram_Depth) words from the in0/in1 SRAMs. It multiplies the lane pairs and
//   adds every product into a single accumulator. It then writes the
//   accumulator to lane 0 of out_addr in the output SRAM, with the other lanes
//   zero, and pulses done.
// Ports
//   clk    : clock. All state changes on the rising edge.
//   rst_n  : asynchronous active-low reset. It aborts a run at once.
//   dpe    : dot_product_engine_if.slave, carrying the control, status and
//            SRAM signals.
// Timing (cycle 0 is the first cycle after start is sampled)
//   READ  cycles 0..L-1 : the read strobes are high and the address equals
//                         the cycle index.
//   DRAIN cycle  L      : the data for the last address accumulates.
//   WRITE cycle  L+1    : one write is issued. For L==0 this is cycle 0.
//   DONE  cycle  L+2    : done pulses. For L==0 this is cycle 1.
// ---------------------------------------------------------------------------
module dot_product_engine #(
  parameter int Data_Width_In  = 8,
  parameter int Data_Width_Out = 16,
  parameter int Addr_Width     = 4,
  parameter int Para_Deg       = 2
) (
  input logic               clk,
  input logic               rst_n,
  dot_product_engine_if.slave dpe
);

  localparam int Ram_Depth = 1 << Addr_Width;
  localparam int Prod_W    = 2 * Data_Width_In;
  // Wide enough for acc + Para_Deg full-scale products without losing the carry.
  localparam int Base_W    = (Prod_W > Data_Width_Out) ? Prod_W : Data_Width_Out;
  localparam int Sum_W     = Base_W + $clog2(Para_Deg + 1) + 1;

  localparam logic [Addr_Width:0] Len_Max = (Addr_Width+1)'(Ram_Depth);
  localparam logic [Addr_Width:0] Len_One = (Addr_Width+1)'(1);
  localparam logic [Addr_Width:0] Len_Zero = (Addr_Width+1)'(0);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_DRAIN = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // Sum of lane-wise products. Each product is widened before the multiply so
  // that it keeps its full 2*Data_Width_In bits.
  function automatic logic [Sum_W-1:0] lane_dot(
    input logic [Para_Deg*Data_Width_In-1:0] a,
    input logic [Para_Deg*Data_Width_In-1:0] b
  );
    logic [Sum_W-1:0]  s;
    logic [Prod_W-1:0] p;
    s = '0;
    for (int i = 0; i < Para_Deg; i++) begin
      p = Prod_W'(a[i*Data_Width_In +: Data_Width_In]) *
          Prod_W'(b[i*Data_Width_In +: Data_Width_In]);
      s = s + Sum_W'(p);
    end
    return s;
  endfunction

  state_t                             state_q;
  logic                               busy_q;
  logic                               done_q;
  logic [Data_Width_Out-1:0]          result_q;
  logic                               ovf_q;
  logic                               in_cs_q;
  logic                               in_en_read_q;
  logic [Addr_Width-1:0]              rd_addr_q;
  logic                               valid_q;
  logic [Addr_Width:0]                len_q;
  logic [Addr_Width-1:0]              out_addr_q;
  logic [Data_Width_Out-1:0]          acc_q;
  logic                               out_cs_q;
  logic                               out_en_write_q;
  logic [Addr_Width-1:0]              wr_addr_q;
  logic [Para_Deg*Data_Width_Out-1:0] wr_data_q;

  logic [Sum_W-1:0]                   sum_wide_d;
  logic [Data_Width_Out-1:0]          acc_d;
  logic                               wrap_d;
  logic [Addr_Width:0]                len_clamp_d;
  logic                               last_addr_d;
  logic [Para_Deg*Data_Width_Out-1:0] wr_data_d;

  // Datapath: next accumulator value, wrap detection, length clamp, write word.
  always_comb begin
    sum_wide_d  = Sum_W'(acc_q) + lane_dot(dpe.in0_read_data, dpe.in1_read_data);
    acc_d       = sum_wide_d[Data_Width_Out-1:0];
    wrap_d      = |sum_wide_d[Sum_W-1:Data_Width_Out];
    if (dpe.len_words > Len_Max) begin
      len_clamp_d = Len_Max;
    end else begin
      len_clamp_d = dpe.len_words;
    end
    last_addr_d = ({1'b0, rd_addr_q} == (len_q - Len_One));
    wr_data_d   = '0;
    wr_data_d[Data_Width_Out-1:0] = acc_d;
  end

  // Control FSM with its registered outputs, accumulator and read pipeline.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      result_q       <= '0;
      ovf_q          <= 1'b0;
      in_cs_q        <= 1'b0;
      in_en_read_q   <= 1'b0;
      rd_addr_q      <= '0;
      valid_q        <= 1'b0;
      len_q          <= '0;
      out_addr_q     <= '0;
      acc_q          <= '0;
      out_cs_q       <= 1'b0;
      out_en_write_q <= 1'b0;
      wr_addr_q      <= '0;
      wr_data_q      <= '0;
    end else begin
      // Read data arrives one cycle after the strobe, so the valid flag lags it.
      valid_q <= in_en_read_q;
      done_q  <= 1'b0;
      if (valid_q) begin
        acc_q <= acc_d;
        if (wrap_d) begin
          ovf_q <= 1'b1;
        end
      end
      case (state_q)
        S_IDLE: begin
          if (dpe.start) begin
            acc_q      <= '0;
            ovf_q      <= 1'b0;
            busy_q     <= 1'b1;
            len_q      <= len_clamp_d;
            out_addr_q <= dpe.out_addr;
            if (len_clamp_d != Len_Zero) begin
              state_q      <= S_READ;
              in_cs_q      <= 1'b1;
              in_en_read_q <= 1'b1;
              rd_addr_q    <= '0;
            end else begin
              // The accumulator is cleared on this edge, so an empty run writes zero.
              state_q        <= S_WRITE;
              out_cs_q       <= 1'b1;
              out_en_write_q <= 1'b1;
              wr_addr_q      <= dpe.out_addr;
              wr_data_q      <= '0;
              result_q       <= '0;
            end
          end
        end
        S_READ: begin
          if (last_addr_d) begin
            state_q      <= S_DRAIN;
            in_cs_q      <= 1'b0;
            in_en_read_q <= 1'b0;
          end else begin
            rd_addr_q <= rd_addr_q + Addr_Width'(1);
          end
        end
        S_DRAIN: begin
          // The last word accumulates on this edge, so take the bypassed sum.
          state_q        <= S_WRITE;
          out_cs_q       <= 1'b1;
          out_en_write_q <= 1'b1;
          wr_addr_q      <= out_addr_q;
          wr_data_q      <= wr_data_d;
          result_q       <= acc_d;
        end
        S_WRITE: begin
          state_q        <= S_DONE;
          out_cs_q       <= 1'b0;
          out_en_write_q <= 1'b0;
          done_q         <= 1'b1;
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q        <= S_IDLE;
          busy_q         <= 1'b0;
          in_cs_q        <= 1'b0;
          in_en_read_q   <= 1'b0;
          out_cs_q       <= 1'b0;
          out_en_write_q <= 1'b0;
        end
      endcase
    end
  end

  assign dpe.busy           = busy_q;
  assign dpe.done           = done_q;
  assign dpe.result         = result_q;
  assign dpe.overflow       = ovf_q;
  assign dpe.in_cs          = in_cs_q;
  assign dpe.in_en_read     = in_en_read_q;
  assign dpe.in_read_addr   = rd_addr_q;
  assign dpe.out_cs         = out_cs_q;
  assign dpe.out_en_write   = out_en_write_q;
  assign dpe.out_write_addr = wr_addr_q;
  assign dpe.out_write_data = wr_data_q;

endmodule

// File: tb/tb_dot_product_engine.sv
// ---------------------------------------------------------------------------
// tb_dot_product_engine
//   Directed bench for dot_product_engine. Small behavioural models of the
//   in0/in1 SRAMs answer reads with a 1-cycle latency. The expected writes are
//   computed from the memory contents when each run starts and are queued.
//   They are popped and compared when the engine writes.
// ---------------------------------------------------------------------------
module tb_dot_product_engine;
  localparam int DWI   = 8;
  localparam int DWO   = 16;
  localparam int AW    = 4;
  localparam int PD    = 2;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  dot_product_engine_if #(.Data_Width_In(DWI), .Data_Width_Out(DWO),
                          .Addr_Width(AW), .Para_Deg(PD)) bus ();

  dot_product_engine #(.Data_Width_In(DWI), .Data_Width_Out(DWO),
                       .Addr_Width(AW), .Para_Deg(PD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .dpe   (bus)
  );

  logic [PD*DWI-1:0] mem0 [DEPTH];
  logic [PD*DWI-1:0] mem1 [DEPTH];

  // Input SRAM models with a 1-cycle read latency.
  always @(posedge clk) begin
    if (bus.in_cs && bus.in_en_read) begin
      bus.in0_read_data <= mem0[bus.in_read_addr];
      bus.in1_read_data <= mem1[bus.in_read_addr];
    end
  end

  typedef struct {
    logic [AW-1:0]     addr;
    logic [PD*DWO-1:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  tests = 0;
  int  fails = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, ".busy"},     64'(bus.busy),           64'd0);
    check({tag, ".done"},     64'(bus.done),           64'd0);
    check({tag, ".overflow"}, 64'(bus.overflow),       64'd0);
    check({tag, ".result"},   64'(bus.result),         64'd0);
    check({tag, ".in_strb"},  64'({bus.in_cs, bus.in_en_read}),   64'd0);
    check({tag, ".out_strb"}, 64'({bus.out_cs, bus.out_en_write}), 64'd0);
    check({tag, ".rd_addr"},  64'(bus.in_read_addr),   64'd0);
    check({tag, ".wr_addr"},  64'(bus.out_write_addr), 64'd0);
    check({tag, ".wr_data"},  64'(bus.out_write_data), 64'd0);
  endtask

  // One run: queue the expected write, pulse start, then watch cycle by cycle.
  // If repulse_cyc >= 0, start is pulsed again (with a new length) in that
  // cycle. If rst_cyc >= 0, reset is asserted in that cycle.
  task automatic run(input string tag, input int len, input int oaddr,
                     input int repulse_cyc, input int rst_cyc,
                     output logic [DWO-1:0] res_o);
    int            l_eff, reads, writes, done_cyc, max_addr;
    bit            seq_ok, ovf, reset_hit;
    longint        total;
    logic [DWO-1:0] res;
    wr_t           e;

    l_eff = (len > DEPTH) ? DEPTH : len;
    total = 0;
    for (int w = 0; w < l_eff; w++) begin
      for (int i = 0; i < PD; i++) begin
        total += longint'(mem0[w][i*DWI +: DWI]) * longint'(mem1[w][i*DWI +: DWI]);
      end
    end
    res   = DWO'(total % 65536);
    ovf   = (total >= 65536);
    res_o = res;
    if (rst_cyc < 0) begin
      exp_q.push_back('{addr: AW'(oaddr), data: {16'd0, res}});
    end

    @(negedge clk);
    bus.start     = 1'b1;
    bus.len_words = (AW+1)'(len);
    bus.out_addr  = AW'(oaddr);
    reads = 0; writes = 0; done_cyc = -1; max_addr = 0; seq_ok = 1'b1; reset_hit = 1'b0;

    for (int cyc = 0; cyc < 60; cyc++) begin
      @(negedge clk);
      if (cyc == 0) begin
        bus.start    = 1'b0;
        bus.out_addr = AW'(oaddr) ^ 4'hF;
      end
      if (cyc == repulse_cyc) begin
        bus.start     = 1'b1;
        bus.len_words = 5'd2;
      end else if (cyc == repulse_cyc + 1) begin
        bus.start = 1'b0;
      end
      if (cyc == rst_cyc) begin
        rst_n = 1'b0;
        #1;
        check_idle_outputs({tag, ".rst"});
        @(negedge clk);
        rst_n     = 1'b1;
        reset_hit = 1'b1;
        break;
      end
      if (bus.in_cs && bus.in_en_read) begin
        if (int'(bus.in_read_addr) != reads || cyc != reads) seq_ok = 1'b0;
        if (int'(bus.in_read_addr) > max_addr) max_addr = int'(bus.in_read_addr);
        reads++;
      end
      if (bus.out_cs && bus.out_en_write) begin
        writes++;
        check({tag, ".wr_cycle"}, 64'(cyc), 64'((l_eff == 0) ? 0 : l_eff + 1));
        if (exp_q.size() == 0) begin
          check({tag, ".unexpected_wr"}, 64'(writes), 64'd0);
        end else begin
          e = exp_q.pop_front();
          check({tag, ".wr_addr"}, 64'(bus.out_write_addr), 64'(e.addr));
          check({tag, ".wr_data"}, 64'(bus.out_write_data), 64'(e.data));
        end
      end
      if (bus.done) begin
        done_cyc = cyc;
        break;
      end
    end

    if (reset_hit) begin
      check({tag, ".writes"}, 64'(writes), 64'd0);
      check({tag, ".idle_after_rst"}, 64'(bus.busy), 64'd0);
    end else begin
      check({tag, ".done_cycle"}, 64'(done_cyc), 64'((l_eff == 0) ? 1 : l_eff + 2));
      check({tag, ".writes"},     64'(writes),   64'd1);
      check({tag, ".reads"},      64'(reads),    64'(l_eff));
      check({tag, ".rd_seq"},     64'(seq_ok),   64'd1);
      check({tag, ".max_addr"},   64'(max_addr), 64'((l_eff == 0) ? 0 : l_eff - 1));
      check({tag, ".result"},     64'(bus.result),   64'(res));
      check({tag, ".overflow"},   64'(bus.overflow), 64'(ovf));
      check({tag, ".busy_done"},  64'(bus.busy),     64'd1);
      @(negedge clk);
      check({tag, ".busy_after"}, 64'(bus.busy), 64'd0);
      check({tag, ".done_after"}, 64'(bus.done), 64'd0);
      check({tag, ".result_hold"}, 64'(bus.result), 64'(res));
    end
    check({tag, ".queue_empty"}, 64'(exp_q.size()), 64'd0);
  endtask

  logic [DWO-1:0] r;

  initial begin
    rst_n         = 1'b1;
    bus.start     = 1'b0;
    bus.len_words = '0;
    bus.out_addr  = '0;
    for (int w = 0; w < DEPTH; w++) begin
      mem0[w] = '0;
      mem1[w] = '0;
    end
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // T1: small known vectors.
    mem0[0] = {8'd2, 8'd1}; mem0[1] = {8'd4, 8'd3};
    mem1[0] = {8'd6, 8'd5}; mem1[1] = {8'd8, 8'd7};
    run("T1", 2, 3, -1, -1, r);
    check("T1.const", 64'(bus.result), 64'd70);

    // T2: full-scale data over the whole SRAM, which wraps the accumulator.
    for (int w = 0; w < DEPTH; w++) begin
      mem0[w] = 16'hFFFF;
      mem1[w] = 16'hFFFF;
    end
    run("T2", 16, 7, -1, -1, r);
    check("T2.const", 64'(bus.result), 64'd49184);
    check("T2.ovf",   64'(bus.overflow), 64'd1);

    // T3: empty run.
    run("T3", 0, 5, -1, -1, r);

    // T4: a second start while busy is ignored.
    for (int w = 0; w < DEPTH; w++) begin
      mem0[w] = 16'($urandom);
      mem1[w] = 16'($urandom);
    end
    run("T4", 4, 9, 1, -1, r);

    // T5: reset mid-run, then a fresh short run.
    run("T5a", 8, 2, -1, 2, r);
    mem0[0] = {8'd3, 8'd2};
    mem1[0] = {8'd5, 8'd4};
    run("T5b", 1, 12, -1, -1, r);
    check("T5.const", 64'(bus.result), 64'd23);

    // T6: an oversized length is clamped to the SRAM depth.
    for (int w = 0; w < DEPTH; w++) begin
      mem0[w] = 16'($urandom);
      mem1[w] = 16'($urandom);
    end
    run("T6", 31, 15, -1, -1, r);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
